tmds_decoder: RTL and testbench

Receive-side counterpart of the per-channel TMDS encoder. It accepts one serial TMDS bit per clock and finds 10-bit symbol alignment from the control-token preambles. Once aligned, it decodes each symbol into an 8-bit pixel byte, a 2-bit control value, or a guard-band indication. One instance serves one channel; three instances plus a sync extractor form the HDMI sink path used for loopback verification of the transmitter.

---
 rtl/tmds_pkg.sv | 18 +
 rtl/tmds_symbol_decode.sv | 36 +++
 rtl/tmds_decoder.sv | 147 ++++++++++++++
 tb/tb_tmds_decoder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS token constants and decoder state type, common to encoder and decoder.
package tmds_pkg;

    localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

    localparam logic [9:0] GUARD_TOKEN_0 = 10'b1011001100;
    localparam logic [9:0] GUARD_TOKEN_1 = 10'b0100110011;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } dec_state_t;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational 10b->8b TMDS data decode plus control/guard token classification.
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [9:0] sym,
    output logic [7:0] data,
    output logic       is_ctrl,
    output logic [1:0] ctrl_val,
    output logic       is_guard
);

    logic [7:0] b;

    always_comb begin
        b    = sym[9] ? ~sym[7:0] : sym[7:0];
        data = '0;
        data[0] = b[0];
        for (int unsigned i = 1; i < 8; i++) begin
            data[i] = sym[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
        end
    end

    always_comb begin
        is_ctrl  = 1'b1;
        ctrl_val = '0;
        case (sym)
            CTRL_TOKEN_00: ctrl_val = 2'b00;
            CTRL_TOKEN_01: ctrl_val = 2'b01;
            CTRL_TOKEN_10: ctrl_val = 2'b10;
            CTRL_TOKEN_11: ctrl_val = 2'b11;
            default:       is_ctrl  = 1'b0;
        endcase
        is_guard = (sym == GUARD_TOKEN_0) || (sym == GUARD_TOKEN_1);
    end

endmodule

// File: rtl/tmds_decoder.sv
// Per-channel TMDS receiver: serial symbol alignment from control preambles and symbol decode.
// Optional TMDS_DECODER_STATS_EN adds a saturating lock_loss_count output.
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int unsigned CTRL_RUN = 4,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic       clk,
    input  logic       s_rst,
    input  logic       serial_in,
    output logic [7:0] pixel_data,
    output logic [1:0] ctrl,
    output logic       data_valid,
    output logic       ctrl_valid,
    output logic       guard_valid,
    output logic       locked
`ifdef TMDS_DECODER_STATS_EN
    ,
    output logic [15:0] lock_loss_count
`endif
);

    localparam int unsigned TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX   = TW'(TIMEOUT);
    localparam logic [3:0]    RUN_TGT = 4'(CTRL_RUN);

    dec_state_t    state, state_nx;
    logic [9:0]    sr;
    logic [3:0]    ph, ph_nx;
    logic [3:0]    run, run_nx;
    logic [TW-1:0] tcount, tcount_nx, tinc;
    logic [7:0]    pixel_nx;
    logic [1:0]    ctrl_nx;
    logic          dv_nx, cv_nx, gv_nx;

    logic [7:0]    sym_data;
    logic          sym_is_ctrl, sym_is_guard;
    logic [1:0]    sym_ctrl;
    logic          boundary;

    tmds_symbol_decode u_symbol_decode (
        .sym      (sr),
        .data     (sym_data),
        .is_ctrl  (sym_is_ctrl),
        .ctrl_val (sym_ctrl),
        .is_guard (sym_is_guard)
    );

    assign boundary = (ph == 4'd9);
    assign locked   = (state == LOCKED);

    always_comb begin
        state_nx  = state;
        ph_nx     = boundary ? 4'd0 : ph + 4'd1;
        run_nx    = run;
        tcount_nx = tcount;
        pixel_nx  = pixel_data;
        ctrl_nx   = ctrl;
        dv_nx     = 1'b0;
        cv_nx     = 1'b0;
        gv_nx     = 1'b0;
        tinc      = (tcount == TMAX) ? tcount : tcount + 1'b1;

        case (state)
            HUNT: begin
                // The matching cycle itself acts as a boundary, so the next one is 10 clks later.
                if (sym_is_ctrl) begin
                    ph_nx    = '0;
                    run_nx   = 4'd1;
                    state_nx = VERIFY;
                end
            end
            VERIFY: begin
                if (boundary) begin
                    if (sym_is_ctrl) begin
                        run_nx = run + 4'd1;
                        if (run + 4'd1 == RUN_TGT) begin
                            state_nx  = LOCKED;
                            tcount_nx = '0;
                        end
                    end else begin
                        state_nx = HUNT;
                    end
                end
            end
            LOCKED: begin
                if (boundary) begin
                    if (sym_is_ctrl) begin
                        cv_nx     = 1'b1;
                        ctrl_nx   = sym_ctrl;
                        tcount_nx = '0;
                    end else begin
                        tcount_nx = tinc;
                        // The symbol that exhausts the timeout is dropped without a pulse.
                        if (tinc == TMAX) begin
                            state_nx = HUNT;
                        end else if (sym_is_guard) begin
                            gv_nx = 1'b1;
                        end else begin
                            dv_nx    = 1'b1;
                            pixel_nx = sym_data;
                        end
                    end
                end
            end
            default: state_nx = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (s_rst) begin
            state       <= HUNT;
            sr          <= '0;
            ph          <= '0;
            run         <= '0;
            tcount      <= '0;
            pixel_data  <= '0;
            ctrl        <= '0;
            data_valid  <= 1'b0;
            ctrl_valid  <= 1'b0;
            guard_valid <= 1'b0;
        end else begin
            state       <= state_nx;
            sr          <= {serial_in, sr[9:1]};
            ph          <= ph_nx;
            run         <= run_nx;
            tcount      <= tcount_nx;
            pixel_data  <= pixel_nx;
            ctrl        <= ctrl_nx;
            data_valid  <= dv_nx;
            ctrl_valid  <= cv_nx;
            guard_valid <= gv_nx;
        end
    end

`ifdef TMDS_DECODER_STATS_EN
    always_ff @(posedge clk) begin
        if (s_rst) begin
            lock_loss_count <= '0;
        end else if (state == LOCKED && state_nx == HUNT && lock_loss_count != 16'hFFFF) begin
            lock_loss_count <= lock_loss_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Scoreboard bench for tmds_decoder: behavioural stream model feeds expected queues, monitor compares.
module tb_tmds_decoder;

    localparam int CR = 4;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       s_rst = 1'b1;
    logic       serial_in = 1'b0;
    logic [7:0] pixel_data;
    logic [1:0] ctrl;
    logic       data_valid, ctrl_valid, guard_valid, locked;
`ifdef TMDS_DECODER_STATS_EN
    logic [15:0] lock_loss_count;
`endif

    tmds_decoder #(.CTRL_RUN(CR), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .s_rst       (s_rst),
        .serial_in   (serial_in),
        .pixel_data  (pixel_data),
        .ctrl        (ctrl),
        .data_valid  (data_valid),
        .ctrl_valid  (ctrl_valid),
        .guard_valid (guard_valid),
        .locked      (locked)
`ifdef TMDS_DECODER_STATS_EN
        ,
        .lock_loss_count (lock_loss_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {int kind; logic [7:0] pix; logic [1:0] c; int cyc;} ev_t;
    typedef struct {bit lk; logic [7:0] pix; logic [1:0] c; int loss; int cyc;} st_t;
    ev_t evq[$];
    st_t stq[$];

    int vectors = 0;
    int miscompares = 0;

    logic [9:0] ctok [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
    logic [9:0] gtok [2] = '{10'b1011001100, 10'b0100110011};

    // Reference model state: mode 0=hunt, 1=verify, 2=locked.
    int         m_mode = 0;
    logic [9:0] m_sr = '0;
    int         m_ph = 0, m_run = 0, m_tc = 0, m_loss = 0, m_cyc = 0;
    logic [7:0] m_pix = '0;
    logic [1:0] m_ctrl = '0;

    function automatic int ctrl_index(logic [9:0] w);
        for (int k = 0; k < 4; k++) if (w == ctok[k]) return k;
        return -1;
    endfunction

    function automatic bit is_guard_tok(logic [9:0] w);
        return (w == gtok[0]) || (w == gtok[1]);
    endfunction

    function automatic logic [7:0] ref_decode(logic [9:0] q);
        logic [7:0] b;
        logic [7:0] x;
        b = q[9] ? ~q[7:0] : q[7:0];
        x = b ^ {b[6:0], 1'b0};
        if (!q[8]) x = ~x;
        return {x[7:1], b[0]};
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        do w = 10'($urandom_range(0, 1023));
        while (ctrl_index(w) >= 0 || is_guard_tok(w));
        return w;
    endfunction

    task automatic model_step(input logic b, input logic r);
        int ci;
        int nph;
        m_cyc++;
        if (r) begin
            m_mode = 0; m_sr = '0; m_ph = 0; m_run = 0; m_tc = 0;
            m_pix = '0; m_ctrl = '0; m_loss = 0;
        end else begin
            ci  = ctrl_index(m_sr);
            nph = (m_ph + 1) % 10;
            if (m_mode == 0) begin
                if (ci >= 0) begin nph = 0; m_run = 1; m_mode = 1; end
            end else if (m_ph == 9) begin
                if (m_mode == 1) begin
                    if (ci >= 0) begin
                        m_run++;
                        if (m_run == CR) begin m_mode = 2; m_tc = 0; end
                    end else m_mode = 0;
                end else begin
                    if (ci >= 0) begin
                        m_ctrl = 2'(ci); m_tc = 0;
                        evq.push_back('{1, m_pix, m_ctrl, m_cyc});
                    end else begin
                        m_tc = (m_tc + 1 > TO) ? TO : m_tc + 1;
                        if (m_tc == TO) begin
                            m_mode = 0;
                            if (m_loss < 65535) m_loss++;
                        end else if (is_guard_tok(m_sr)) begin
                            evq.push_back('{2, m_pix, m_ctrl, m_cyc});
                        end else begin
                            m_pix = ref_decode(m_sr);
                            evq.push_back('{0, m_pix, m_ctrl, m_cyc});
                        end
                    end
                end
            end
            m_ph = nph;
            m_sr = {b, m_sr[9:1]};
        end
        stq.push_back('{m_mode == 2, m_pix, m_ctrl, m_loss, m_cyc});
    endtask

    task automatic drive_bit(input logic b, input logic r);
        @(negedge clk);
        serial_in = b;
        s_rst = r;
        @(posedge clk);
        model_step(b, r);
    endtask

    task automatic send_sym(input logic [9:0] w);
        for (int i = 0; i < 10; i++) drive_bit(w[i], 1'b0);
    endtask

    // Monitor: one status record per cycle; events popped whenever the DUT pulses.
    initial begin
        st_t st;
        ev_t e;
        int cur = -1;
        int nhigh;
        int kind;
        forever begin
            @(posedge clk);
            #1;
            if (stq.size() > 0) begin
                st = stq.pop_front();
                cur = st.cyc;
                vectors++;
                if (locked !== st.lk) begin
                    miscompares++;
                    $display("FAIL locked cyc=%0d got=%b exp=%b", cur, locked, st.lk);
                end
                vectors++;
                if ({pixel_data, ctrl} !== {st.pix, st.c}) begin
                    miscompares++;
                    $display("FAIL held_outputs cyc=%0d got pix=%h ctrl=%b exp pix=%h ctrl=%b",
                             cur, pixel_data, ctrl, st.pix, st.c);
                end
`ifdef TMDS_DECODER_STATS_EN
                vectors++;
                if (lock_loss_count !== 16'(st.loss)) begin
                    miscompares++;
                    $display("FAIL lock_loss_count cyc=%0d got=%0d exp=%0d", cur, lock_loss_count, st.loss);
                end
`endif
                while (evq.size() > 0 && evq[0].cyc < cur) begin
                    e = evq.pop_front();
                    vectors++;
                    miscompares++;
                    $display("FAIL missed_pulse cyc=%0d got=none exp kind=%0d", e.cyc, e.kind);
                end
            end
            nhigh = int'(data_valid === 1'b1) + int'(ctrl_valid === 1'b1) + int'(guard_valid === 1'b1);
            kind  = (data_valid === 1'b1) ? 0 : (ctrl_valid === 1'b1) ? 1 : 2;
            if (nhigh > 0) begin
                vectors++;
                if (evq.size() == 0 || evq[0].cyc != cur) begin
                    miscompares++;
                    $display("FAIL unexpected_pulse cyc=%0d got kind=%0d exp=none", cur, kind);
                end else begin
                    e = evq.pop_front();
                    if (nhigh != 1 || kind != e.kind) begin
                        miscompares++;
                        $display("FAIL pulse_kind cyc=%0d got kind=%0d n=%0d exp kind=%0d", cur, kind, nhigh, e.kind);
                    end
                end
            end
        end
    end

    initial begin
        bit done;
        int r;
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b1);

        // Acquisition from an arbitrary bit offset.
        for (int i = 0; i < 3; i++) drive_bit(1'($urandom_range(0, 1)), 1'b0);
        for (int i = 0; i < 6; i++) send_sym(ctok[0]);

        // Data decode, then guard and control mix.
        send_sym(10'b0100000000);
        send_sym(10'b1111111111);
        send_sym(10'b0111111111);
        send_sym(gtok[0]);
        send_sym(ctok[2]);

        // Randomised traffic keeping the link mostly alive.
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 7);
            if (r < 2)       send_sym(ctok[$urandom_range(0, 3)]);
            else if (r == 2) send_sym(gtok[$urandom_range(0, 1)]);
            else             send_sym(10'($urandom_range(0, 1023)));
        end

        // Fresh lock, then timeout on 16 consecutive data symbols.
        drive_bit(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) send_sym(ctok[0]);
        for (int i = 0; i < 16; i++) send_sym(rand_data());
        for (int i = 0; i < 3; i++) send_sym(rand_data());

        // Verification broken by a data symbol before CTRL_RUN tokens.
        drive_bit(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) send_sym(ctok[1]);
        send_sym(10'b0100000000);
        for (int i = 0; i < 2; i++) send_sym(rand_data());

        // Lock, then reset mid-symbol at ph=5.
        for (int i = 0; i < 5; i++) send_sym(ctok[0]);
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (m_mode == 2 && m_ph == 5) begin
                drive_bit(1'b1, 1'b1);
                done = 1'b1;
            end else begin
                drive_bit(1'($urandom_range(0, 1)), 1'b0);
            end
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL midrun_reset_window got=not_locked exp=locked");
        end
        for (int i = 0; i < 3; i++) send_sym(ctok[3]);
        send_sym(rand_data());
        for (int i = 0; i < 5; i++) send_sym(ctok[3]);
        for (int i = 0; i < 4; i++) send_sym(rand_data());
        for (int i = 0; i < 12; i++) drive_bit(1'b0, 1'b0);

        @(posedge clk);
        #2;
        vectors++;
        if (evq.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_events got=%0d exp=0", evq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
